aes_round_sequencer: RTL and testbench

- Parametrised iterative AES round controller. Generalises the fixed AES-128 encrypt-then-decrypt top to AES-128/192/256.
- Adds a start/busy/done handshake, a selectable mode (encrypt, decrypt, round-trip self-test) and a round-trip match check.
- Drives the team's combinational round datapath: one round per clock.
- Sits between the board/top-level wrapper and the round unit.

---
 rtl/aes_round_sequencer_if.sv | 63 ++++++
 rtl/aes_round_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_sequencer_if.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer_if
//
// Purpose: bundles the host handshake and the round-unit connection of the
// iterative AES round sequencer into one interface.
//
// Parameter:
//   NK          key length in 32-bit words (4/6/8); key buses are 32*NK wide
//
// Signals (direction as seen by the sequencer, modport slave):
//   start       in   request, accepted only when the sequencer is idle
//   mode        in   00 encrypt, 01 decrypt, 10 round-trip, 11 reserved
//   data_in     in   plaintext or ciphertext, sampled on the accept edge
//   key_in      in   cipher key, sampled on the accept edge
//   rnd_result  in   combinational round-unit result
//   rnd_state   out  current state register, to round unit
//   rnd_key     out  latched key, to round unit
//   rnd_idx     out  round index, to round unit
//   rnd_dir     out  0 = encrypt round, 1 = decrypt round
//   busy        out  operation in progress
//   done        out  one-cycle completion pulse
//   data_out    out  final result, held until the next done
//   ct_out      out  intermediate ciphertext of the last round-trip
//   match       out  round-trip decrypt result equals the original input
//   err         out  one-cycle pulse on a start with the reserved mode
//
// Modports: slave = sequencer, master = host plus round unit.
// -----------------------------------------------------------------------------
interface aes_round_sequencer_if #(
    parameter int NK = 4
) ();
    localparam int KEY_W = 32 * NK;

    logic             start;
    logic [1:0]       mode;
    logic [127:0]     data_in;
    logic [KEY_W-1:0] key_in;

    logic [127:0]     rnd_state;
    logic [KEY_W-1:0] rnd_key;
    logic [3:0]       rnd_idx;
    logic             rnd_dir;
    logic [127:0]     rnd_result;

    logic             busy;
    logic             done;
    logic [127:0]     data_out;
    logic [127:0]     ct_out;
    logic             match;
    logic             err;

    modport slave (
        input  start, mode, data_in, key_in, rnd_result,
        output rnd_state, rnd_key, rnd_idx, rnd_dir,
        output busy, done, data_out, ct_out, match, err
    );

    modport master (
        output start, mode, data_in, key_in, rnd_result,
        input  rnd_state, rnd_key, rnd_idx, rnd_dir,
        input  busy, done, data_out, ct_out, match, err
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//
// Purpose: iterative AES-128/192/256 round controller. Holds the cipher state
// and key, steps an external combinational round unit one round per clock,
// and offers encrypt, decrypt and round-trip (encrypt then decrypt with a
// match check against the original input) operations behind a
// start/busy/done handshake.
//
// Parameter:
//   NK     key length in 32-bit words: 4, 6 or 8. NR = NK+6 rounds.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset; aborts any operation
//   bus    aes_round_sequencer_if.slave: host handshake (start, mode,
//          data_in, key_in, busy, done, data_out, ct_out, match, err) and
//          round-unit link (rnd_state, rnd_key, rnd_idx, rnd_dir, rnd_result)
//
// Optional feature: define AES_SEQ_TRACE_EN to get a simulation-only
// per-round trace. Leave it undefined for synthesis.
// -----------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int NK = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_round_sequencer_if.slave bus
);
    localparam int         NR     = NK + 6;
    localparam int         KEY_W  = 32 * NK;
    localparam logic [3:0] NR_IDX = 4'(NR);

    localparam logic [1:0] MODE_DEC  = 2'b01;
    localparam logic [1:0] MODE_RT   = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_round_sequencer: NK must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_DEC  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [127:0]     st_q, st_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [127:0]     pt_q, pt_d;
    logic [3:0]       idx_q, idx_d;
    logic             dir_q, dir_d;
    logic             rt_q, rt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [127:0]     data_out_q, data_out_d;
    logic [127:0]     ct_out_q, ct_out_d;
    logic             match_q, match_d;
    logic             err_q, err_d;

    always_comb begin
        state_d    = state_q;
        st_d       = st_q;
        key_d      = key_q;
        pt_d       = pt_q;
        idx_d      = idx_q;
        dir_d      = dir_q;
        rt_d       = rt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        data_out_d = data_out_q;
        ct_out_d   = ct_out_q;
        match_d    = match_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.mode == MODE_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        st_d  = bus.data_in;
                        key_d = bus.key_in;
                        pt_d  = bus.data_in;
                        if (bus.mode == MODE_DEC) begin
                            idx_d   = NR_IDX;
                            dir_d   = 1'b1;
                            rt_d    = 1'b0;
                            state_d = S_DEC;
                        end else begin
                            idx_d   = 4'd0;
                            dir_d   = 1'b0;
                            rt_d    = (bus.mode == MODE_RT);
                            state_d = S_ENC;
                        end
                    end
                end
            end

            S_ENC: begin
                st_d = bus.rnd_result;
                // Terminal test comes first so idx stays at NR instead of
                // stepping past the last round.
                if (idx_q == NR_IDX) begin
                    if (rt_q) begin
                        // Round-trip: keep the ciphertext and run the inverse
                        // cipher on it starting from the last round key.
                        ct_out_d = bus.rnd_result;
                        dir_d    = 1'b1;
                        state_d  = S_DEC;
                    end else begin
                        data_out_d = bus.rnd_result;
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                    end
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end

            S_DEC: begin
                st_d = bus.rnd_result;
                // Terminal test comes first so idx never wraps below zero.
                if (idx_q == 4'd0) begin
                    data_out_d = bus.rnd_result;
                    done_d     = 1'b1;
                    match_d    = rt_q && (bus.rnd_result == pt_q);
                    rt_d       = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    idx_d = idx_q - 4'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // busy tracks the state being entered, so it is already low in the
    // cycle where done is high and already high right after an accept.
    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            st_q       <= '0;
            key_q      <= '0;
            pt_q       <= '0;
            idx_q      <= '0;
            dir_q      <= 1'b0;
            rt_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
            ct_out_q   <= '0;
            match_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            st_q       <= st_d;
            key_q      <= key_d;
            pt_q       <= pt_d;
            idx_q      <= idx_d;
            dir_q      <= dir_d;
            rt_q       <= rt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
            ct_out_q   <= ct_out_d;
            match_q    <= match_d;
            err_q      <= err_d;
        end
    end

    assign bus.rnd_state = st_q;
    assign bus.rnd_key   = key_q;
    assign bus.rnd_idx   = idx_q;
    assign bus.rnd_dir   = dir_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.data_out  = data_out_q;
    assign bus.ct_out    = ct_out_q;
    assign bus.match     = match_q;
    assign bus.err       = err_q;

`ifdef AES_SEQ_TRACE_EN
    // Simulation-only round trace; mode is reconstructed from rt/dir.
    always @(posedge clk) begin
        if (rst_n && state_q != S_IDLE) begin
            $display("[aes_seq] mode=%b dir=%0d idx=%0d state=%h result=%h",
                     rt_q ? 2'b10 : {1'b0, dir_q}, dir_q, idx_q, st_q,
                     bus.rnd_result);
        end
        if (rst_n && done_q) begin
            $display("[aes_seq] done data_out=%h match=%0d", data_out_q, match_q);
        end
    end
`else
    // Trace disabled: the sequencer produces no simulation output.
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
module tb_aes_round_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic flip4;

    always #5 clk = ~clk;

    aes_round_sequencer_if #(.NK(4)) bus4 ();
    aes_round_sequencer_if #(.NK(8)) bus8 ();

    aes_round_sequencer #(.NK(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    aes_round_sequencer #(.NK(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] KEY256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    // ---------------- reference AES round unit ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r, p;
        r = 8'h01; p = a;
        for (int i = 0; i < 8; i++) begin   // a^254 = a^(2+4+...+128)
            if (i != 0) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int r);
        logic [31:0] w [64];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4*(r+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] st, input logic inv);
        logic [127:0] o;
        int k, ks;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                k  = 4*c + r;
                ks = 4*((c + r) % 4) + r;
                if (!inv) o[127-8*k -: 8]  = sbox(st[127-8*ks -: 8]);
                else      o[127-8*ks -: 8] = inv_sbox(st[127-8*k -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] st, input logic inv);
        logic [7:0]   m [4];
        logic [7:0]   a [4];
        logic [7:0]   b;
        logic [127:0] o;
        o = '0;
        if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
        else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = st[127-8*(4*c+j) -: 8];
            for (int r = 0; r < 4; r++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b = b ^ gmul(m[(j - r + 4) % 4], a[j]);
                o[127-8*(4*c+r) -: 8] = b;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [255:0] key,
                                               input int nk, input logic [3:0] idx, input logic dir);
        int nr;
        logic [127:0] rk, s;
        nr = nk + 6;
        rk = round_key(key, nk, int'(idx));
        if (!dir) begin
            if (idx == 4'd0) return st ^ rk;
            s = sub_shift(st, 1'b0);
            if (int'(idx) != nr) s = mix(s, 1'b0);
            return s ^ rk;
        end
        if (int'(idx) == nr) return st ^ rk;
        s = sub_shift(st, 1'b1) ^ rk;
        if (idx != 4'd0) s = mix(s, 1'b1);
        return s;
    endfunction

    assign bus4.rnd_result = aes_round(bus4.rnd_state, {bus4.rnd_key, 128'h0}, 4,
                                       bus4.rnd_idx, bus4.rnd_dir) ^ (flip4 ? 128'h1 : 128'h0);
    assign bus8.rnd_result = aes_round(bus8.rnd_state, bus8.rnd_key, 8,
                                       bus8.rnd_idx, bus8.rnd_dir);

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic run_op4(input logic [1:0] mode, input logic [127:0] din, input int flip_at,
                           output int lat, output bit seq_bad);
        int k, eidx;
        bit edir;
        @(posedge clk); #1;
        bus4.start = 1'b1; bus4.mode = mode; bus4.data_in = din; bus4.key_in = KEY128;
        @(posedge clk); #1;
        bus4.start = 1'b0; bus4.data_in = '1; bus4.key_in = '1;
        k = 0; seq_bad = 1'b0; lat = -1;
        while (k < 60) begin
            if (bus4.done) begin lat = k; break; end
            if (mode == 2'b01)  begin eidx = 10 - k; edir = 1'b1; end
            else if (k <= 10)   begin eidx = k;      edir = 1'b0; end
            else                begin eidx = 21 - k; edir = 1'b1; end
            if (bus4.rnd_idx !== 4'(eidx) || bus4.rnd_dir !== edir || bus4.busy !== 1'b1)
                seq_bad = 1'b1;
            flip4 = (k == flip_at);
            @(posedge clk); #1;
            k++;
        end
        flip4 = 1'b0;
    endtask

    task automatic run_dec8(input logic [127:0] din, output int lat, output bit seq_bad);
        int k;
        @(posedge clk); #1;
        bus8.start = 1'b1; bus8.mode = 2'b01; bus8.data_in = din; bus8.key_in = KEY256;
        @(posedge clk); #1;
        bus8.start = 1'b0; bus8.data_in = '1; bus8.key_in = '1;
        k = 0; seq_bad = 1'b0; lat = -1;
        while (k < 60) begin
            if (bus8.done) begin lat = k; break; end
            if (bus8.rnd_idx !== 4'(14 - k) || bus8.rnd_dir !== 1'b1 || bus8.busy !== 1'b1)
                seq_bad = 1'b1;
            @(posedge clk); #1;
            k++;
        end
    endtask

    // ---------------- test tasks ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        flip4 = 1'b0;
        bus4.start = 1'b0; bus4.mode = 2'b00; bus4.data_in = '0; bus4.key_in = '0;
        bus8.start = 1'b0; bus8.mode = 2'b00; bus8.data_in = '0; bus8.key_in = '0;
        #12;
        tests_run++;
        if ({bus4.busy, bus4.done, bus4.match, bus4.err, bus4.rnd_dir} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, want 00000",
                     {bus4.busy, bus4.done, bus4.match, bus4.err, bus4.rnd_dir});
        end
        tests_run++;
        if (bus4.rnd_idx !== 4'd0) begin
            tests_failed++; $display("FAIL reset_idx: got %0d, want 0", bus4.rnd_idx);
        end
        tests_run++;
        if (bus4.data_out !== 128'h0 || bus4.ct_out !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: data_out %h ct_out %h, want 0", bus4.data_out, bus4.ct_out);
        end
        tests_run++;
        if (bus4.rnd_state !== 128'h0 || bus4.rnd_key !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_state_key: state %h key %h, want 0", bus4.rnd_state, bus4.rnd_key);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({bus4.busy, bus4.done, bus8.busy, bus8.done, bus8.data_out} !== 132'h0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: busy4 %b done4 %b busy8 %b done8 %b",
                     bus4.busy, bus4.done, bus8.busy, bus8.done);
        end
    endtask

    task automatic test_encrypt();
        int lat; bit bad;
        run_op4(2'b00, PT, -1, lat, bad);
        tests_run++;
        if (lat !== 11) begin tests_failed++; $display("FAIL enc_latency: got %0d, want 11", lat); end
        tests_run++;
        if (bad !== 1'b0) begin tests_failed++; $display("FAIL enc_idx_seq: got bad=%0d, want 0", bad); end
        tests_run++;
        if (bus4.data_out !== CT128) begin
            tests_failed++; $display("FAIL enc_data_out: got %h, want %h", bus4.data_out, CT128);
        end
        tests_run++;
        if (bus4.busy !== 1'b0) begin tests_failed++; $display("FAIL enc_busy_at_done: got %b, want 0", bus4.busy); end
        @(posedge clk); #1;
        tests_run++;
        if (bus4.done !== 1'b0 || bus4.data_out !== CT128) begin
            tests_failed++;
            $display("FAIL enc_done_pulse_hold: done %b data_out %h, want 0 %h", bus4.done, bus4.data_out, CT128);
        end
    endtask

    task automatic test_roundtrip();
        int lat; bit bad;
        run_op4(2'b10, PT, -1, lat, bad);
        tests_run++;
        if (lat !== 22) begin tests_failed++; $display("FAIL rt_latency: got %0d, want 22", lat); end
        tests_run++;
        if (bad !== 1'b0) begin tests_failed++; $display("FAIL rt_idx_dir_seq: got bad=%0d, want 0", bad); end
        tests_run++;
        if (bus4.ct_out !== CT128) begin
            tests_failed++; $display("FAIL rt_ct_out: got %h, want %h", bus4.ct_out, CT128);
        end
        tests_run++;
        if (bus4.data_out !== PT) begin
            tests_failed++; $display("FAIL rt_data_out: got %h, want %h", bus4.data_out, PT);
        end
        tests_run++;
        if (bus4.match !== 1'b1) begin tests_failed++; $display("FAIL rt_match: got %b, want 1", bus4.match); end
    endtask

    task automatic test_roundtrip_fault();
        int lat; bit bad;
        run_op4(2'b10, PT, 15, lat, bad);
        tests_run++;
        if (lat !== 22) begin tests_failed++; $display("FAIL rtf_latency: got %0d, want 22", lat); end
        tests_run++;
        if (bus4.match !== 1'b0) begin tests_failed++; $display("FAIL rtf_match: got %b, want 0", bus4.match); end
        tests_run++;
        if (bus4.data_out === PT) begin
            tests_failed++; $display("FAIL rtf_data_out: got %h, want anything but %h", bus4.data_out, PT);
        end
    endtask

    task automatic test_decrypt256();
        int lat; bit bad;
        run_dec8(CT256, lat, bad);
        tests_run++;
        if (lat !== 15) begin tests_failed++; $display("FAIL dec256_latency: got %0d, want 15", lat); end
        tests_run++;
        if (bad !== 1'b0) begin tests_failed++; $display("FAIL dec256_idx_seq: got bad=%0d, want 0", bad); end
        tests_run++;
        if (bus8.data_out !== PT) begin
            tests_failed++; $display("FAIL dec256_data_out: got %h, want %h", bus8.data_out, PT);
        end
        tests_run++;
        if (bus8.match !== 1'b0 || bus8.busy !== 1'b0) begin
            tests_failed++; $display("FAIL dec256_match_busy: match %b busy %b, want 0 0", bus8.match, bus8.busy);
        end
    endtask

    task automatic test_reserved();
        bit seen;
        @(posedge clk); #1;
        bus4.start = 1'b1; bus4.mode = 2'b11;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        tests_run++;
        if (bus4.err !== 1'b1 || bus4.busy !== 1'b0) begin
            tests_failed++; $display("FAIL rsvd_err: err %b busy %b, want 1 0", bus4.err, bus4.busy);
        end
        @(posedge clk); #1;
        tests_run++;
        if (bus4.err !== 1'b0) begin tests_failed++; $display("FAIL rsvd_err_pulse: got %b, want 0", bus4.err); end
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus4.busy || bus4.done) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin tests_failed++; $display("FAIL rsvd_no_op: got activity=%0d, want 0", seen); end
    endtask

    task automatic test_busy_ignore();
        int dones, errs, done_k;
        @(posedge clk); #1;
        bus4.start = 1'b1; bus4.mode = 2'b00; bus4.data_in = PT; bus4.key_in = KEY128;
        @(posedge clk); #1;
        dones = 0; errs = 0; done_k = -1;
        for (int k = 0; k < 30; k++) begin
            bus4.start   = (k == 3 || k == 6);
            bus4.mode    = (k == 6) ? 2'b11 : 2'b01;
            bus4.data_in = '0;
            @(posedge clk); #1;
            if (bus4.done) begin dones++; done_k = k + 1; end
            if (bus4.err) errs++;
        end
        bus4.start = 1'b0;
        tests_run++;
        if (dones !== 1 || done_k !== 11) begin
            tests_failed++; $display("FAIL busy_ignore_done: dones %0d at %0d, want 1 at 11", dones, done_k);
        end
        tests_run++;
        if (errs !== 0 || bus4.data_out !== CT128) begin
            tests_failed++;
            $display("FAIL busy_ignore_result: errs %0d data_out %h, want 0 %h", errs, bus4.data_out, CT128);
        end
    endtask

    task automatic test_reset_abort();
        int lat, dones; bit bad;
        @(posedge clk); #1;
        bus4.start = 1'b1; bus4.mode = 2'b10; bus4.data_in = PT; bus4.key_in = KEY128;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        repeat (5) @(posedge clk);
        #3; rst_n = 1'b0; #1;
        tests_run++;
        if ({bus4.busy, bus4.done, bus4.match, bus4.err, bus4.rnd_dir, bus4.rnd_idx} !== 9'b0) begin
            tests_failed++;
            $display("FAIL abort_flags: busy %b done %b match %b err %b dir %b idx %0d, want all 0",
                     bus4.busy, bus4.done, bus4.match, bus4.err, bus4.rnd_dir, bus4.rnd_idx);
        end
        tests_run++;
        if (bus4.data_out !== 128'h0 || bus4.ct_out !== 128'h0 || bus4.rnd_state !== 128'h0) begin
            tests_failed++;
            $display("FAIL abort_data: data_out %h ct_out %h state %h, want 0",
                     bus4.data_out, bus4.ct_out, bus4.rnd_state);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus4.done || bus4.busy) dones++;
        end
        tests_run++;
        if (dones !== 0) begin tests_failed++; $display("FAIL abort_no_done: got %0d active cycles, want 0", dones); end
        run_op4(2'b00, PT, -1, lat, bad);
        tests_run++;
        if (lat !== 11 || bus4.data_out !== CT128) begin
            tests_failed++;
            $display("FAIL abort_rerun: latency %0d data_out %h, want 11 %h", lat, bus4.data_out, CT128);
        end
    endtask

    task automatic test_back_to_back();
        int dones, ph; bit bad;
        @(posedge clk); #1;
        bus4.start = 1'b1; bus4.mode = 2'b00; bus4.data_in = PT; bus4.key_in = KEY128;
        @(posedge clk); #1;
        dones = 0; bad = 1'b0;
        for (int k = 0; k < 36; k++) begin
            ph = k % 12;
            if (ph == 11) begin
                if (!bus4.done || bus4.busy || bus4.data_out !== CT128) bad = 1'b1;
                else dones++;
            end else if (!bus4.busy || bus4.done || bus4.rnd_idx !== 4'(ph) || bus4.rnd_dir) begin
                bad = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus4.start = 1'b0;
        tests_run++;
        if (bad !== 1'b0) begin tests_failed++; $display("FAIL b2b_sequence: got bad=%0d, want 0", bad); end
        tests_run++;
        if (dones !== 3) begin tests_failed++; $display("FAIL b2b_done_count: got %0d, want 3", dones); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_encrypt();
        test_roundtrip();
        test_roundtrip_fault();
        test_decrypt256();
        test_reserved();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
